reaction_timer_dp: RTL and testbench
====================================

Name: reaction_timer_dp

Overview:
Timing datapath that answers the reaction-test control FSM. It takes start_rwait, start_wait5, time_clr, time_en and rs_en, and returns rwait_done, wait5_done and time_late. It contains a millisecond prescaler, an LFSR-randomised wait timer, a 5 s hold timer and a reaction-time counter. It also holds last and best results for the display path.

Parameters:
MS_DIV, 100000, clk cycles per 1 ms tick (100 MHz clk)
RWAIT_MIN_MS, 1000, minimum random wait in ms
RAND_BITS, 12, LFSR bits added to the minimum wait (max wait = RWAIT_MIN_MS + 2^RAND_BITS - 1)
WAIT5_MS, 5000, hold-timer length in ms
LATE_MS, 9999, reaction-time saturation/late threshold in ms
TW, 14, width of the time/result outputs
LFSR_SEED, 16'hACE1, LFSR reset value (nonzero)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-low
start_rwait  in  1  load the random wait and start its countdown
start_wait5  in  1  level; the hold timer runs while high
time_clr  in  1  clear the reaction counter and the prescaler
time_en  in  1  advance the reaction counter on ticks
rs_en  in  1  result store; the rising edge captures the result
rwait_done  out  1  level; the random wait has expired
wait5_done  out  1  level; the hold timer has reached WAIT5_MS
time_late  out  1  level; time_ms == LATE_MS
time_ms  out  TW  live reaction time in ms
last_ms  out  TW  most recently stored result
best_ms  out  TW  minimum stored result
best_valid  out  1  at least one result has been stored

Behaviour:
- Reset (rst==0 at a clk edge):
  - All counters 0; rwait_done, wait5_done, time_late, best_valid = 0.
  - last_ms = 0; best_ms = all ones; lfsr = LFSR_SEED; the rs_en edge register is cleared.
- Prescaler:
  - Counts 0..MS_DIV-1 and wraps. tick is a 1-cycle pulse in the cycle count == MS_DIV-1.
  - time_clr forces the count to 0, which aligns reaction timing to exact ms.
- LFSR:
  - 16-bit Galois, mask 16'hB400, shifts right every clk.
  - It is never reset except by rst, so its value depends on when the user presses start.
- Random wait:
  - start_rwait==1: rwait_cnt <= RWAIT_MIN_MS + lfsr[RAND_BITS-1:0]; rwait_busy <= 1; rwait_done <= 0.
  - While busy, each tick decrements the count. On the tick where the count goes 1->0: busy <= 0, rwait_done <= 1.
  - rwait_done holds until the next start_rwait or rst.
  - start_rwait held for several cycles reloads every cycle; the countdown begins after it drops.
- Hold timer:
  - start_wait5==0: counter and wait5_done are cleared the next cycle.
  - start_wait5==1: increments on tick and saturates at WAIT5_MS.
  - wait5_done <= 1 in the cycle after the count reaches WAIT5_MS. It stays high while start_wait5 stays high.
  - Dropping start_wait5 mid-count discards progress; re-asserting it starts again from 0.
- Reaction counter:
  - Priority is time_clr > (time_en & tick).
  - Increments and saturates at LATE_MS.
  - time_late is registered: set in the same edge where time_ms becomes LATE_MS, cleared by time_clr or rst.
  - time_clr and time_en together: clear wins.
  - time_en low freezes time_ms.
- Result store:
  - On the rs_en rising edge (rs_en & ~rs_en_q): last_ms <= time_ms.
  - If time_ms < best_ms: best_ms <= time_ms. best_valid <= 1.
  - rs_en held high causes no further captures.
  - A capture of exactly LATE_MS is stored normally.
- All outputs are registered; the only latency is 1 cycle from cause to flag.

Test Plan:
- Reset and defaults (MS_DIV=4): drive rst=0 for 3 cycles → every flag 0, time_ms=0, last_ms=0, best_ms=16383, best_valid=0.
- Random wait (RWAIT_MIN_MS=10, RAND_BITS=2): pulse start_rwait; the bench LFSR model predicts lfsr[1:0]=k → rwait_done rises after exactly (10+k) ticks ±1 tick and stays high. A second start_rwait clears it the next cycle.
- Measurement and best tracking:
  - time_clr 1 cycle, then time_en for 250 ticks, then rs_en rise → time_ms=250, last_ms=250, best_ms=250, best_valid=1.
  - Repeat with 300 ticks → last_ms=300, best_ms=250.
  - Repeat with 120 ticks → best_ms=120.
- Late saturation (LATE_MS=20): time_en held for 30 ticks → time_ms stops at 20, and time_late rises on the 20th tick and holds. time_clr → time_ms=0 and time_late=0 the next cycle. time_clr and time_en high together → time_ms stays 0.
- Hold timer (WAIT5_MS=50):
  - start_wait5 held → wait5_done rises 1 cycle after tick 50.
  - Drop it at tick 30 → count 0 and no done; re-assert → done only after a full 50 more ticks.
- Reset mid-operation: rst=0 during a random-wait countdown → after release rwait_done stays 0 indefinitely with no start_rwait, and best_ms returns to 16383.

Source files
------------

// File: rtl/reaction_timer_dp_if.sv
// Control/status bundle between the reaction-test FSM (master) and the
// timing datapath (slave).
interface reaction_timer_dp_if #(
   parameter int TW = 14
);
   logic          start_rwait;
   logic          start_wait5;
   logic          time_clr;
   logic          time_en;
   logic          rs_en;
   logic          rwait_done;
   logic          wait5_done;
   logic          time_late;
   logic [TW-1:0] time_ms;
   logic [TW-1:0] last_ms;
   logic [TW-1:0] best_ms;
   logic          best_valid;

   modport master (
      output start_rwait, start_wait5, time_clr, time_en, rs_en,
      input  rwait_done, wait5_done, time_late, time_ms, last_ms, best_ms, best_valid
   );

   modport slave (
      input  start_rwait, start_wait5, time_clr, time_en, rs_en,
      output rwait_done, wait5_done, time_late, time_ms, last_ms, best_ms, best_valid
   );
endinterface

// File: rtl/reaction_timer_dp.sv
// Reaction-test timing datapath: ms prescaler, LFSR-randomised wait,
// hold timer, saturating reaction counter and last/best result store.
module reaction_timer_dp #(
   parameter int          MS_DIV       = 100000,
   parameter int          RWAIT_MIN_MS = 1000,
   parameter int          RAND_BITS    = 12,
   parameter int          WAIT5_MS     = 5000,
   parameter int          LATE_MS      = 9999,
   parameter int          TW           = 14,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input logic                 clk,
   input logic                 rst,
   reaction_timer_dp_if.slave  bus
);

   localparam int PW  = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
   localparam int RWW = $clog2(RWAIT_MIN_MS + (1 << RAND_BITS)) + 1;
   localparam int HW  = $clog2(WAIT5_MS + 1) + 1;

   localparam logic [PW-1:0]  PRE_MAX   = PW'(MS_DIV - 1);
   localparam logic [RWW-1:0] RWAIT_MIN = RWW'(RWAIT_MIN_MS);
   localparam logic [RWW-1:0] RW_ONE    = RWW'(1);
   localparam logic [HW-1:0]  HOLD_MAX  = HW'(WAIT5_MS);
   localparam logic [TW-1:0]  LATE_VAL  = TW'(LATE_MS);
   localparam logic [TW-1:0]  LATE_PRE  = TW'(LATE_MS - 1);

   logic [PW-1:0]  r_pre;
   logic [15:0]    r_lfsr;
   logic [RWW-1:0] r_rwait_cnt;
   logic           r_rwait_busy;
   logic           r_rwait_done;
   logic [HW-1:0]  r_hold_cnt;
   logic           r_wait5_done;
   logic [TW-1:0]  r_time;
   logic           r_time_late;
   logic           r_rs_q;
   logic [TW-1:0]  r_last;
   logic [TW-1:0]  r_best;
   logic           r_best_valid;

   logic           w_tick;
   logic           w_time_inc;
   logic           w_rs_rise;

   // Saturating increment of the reaction time at the late threshold.
   function automatic logic [TW-1:0] sat_inc_time(input logic [TW-1:0] v);
      return (v == LATE_VAL) ? v : v + TW'(1);
   endfunction

   // Saturating increment of the hold counter at its terminal value.
   function automatic logic [HW-1:0] sat_inc_hold(input logic [HW-1:0] v);
      return (v == HOLD_MAX) ? v : v + HW'(1);
   endfunction

   assign w_tick     = (r_pre == PRE_MAX);
   assign w_time_inc = bus.time_en & w_tick;
   assign w_rs_rise  = bus.rs_en & ~r_rs_q;

   // Millisecond prescaler; time_clr realigns it so reaction time starts on an exact ms.
   always_ff @(posedge clk) begin
      if (!rst)              r_pre <= '0;
      else if (bus.time_clr) r_pre <= '0;
      else if (w_tick)       r_pre <= '0;
      else                   r_pre <= r_pre + PW'(1);
   end

   // Free-running Galois LFSR; its phase at start_rwait supplies the randomness.
   always_ff @(posedge clk) begin
      if (!rst) r_lfsr <= LFSR_SEED;
      else      r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
   end

   // Random wait: load min + random offset, count down on ticks, flag on 1->0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rwait_cnt  <= '0;
         r_rwait_busy <= 1'b0;
         r_rwait_done <= 1'b0;
      end else if (bus.start_rwait) begin
         r_rwait_cnt  <= RWAIT_MIN + RWW'(r_lfsr[RAND_BITS-1:0]);
         r_rwait_busy <= 1'b1;
         r_rwait_done <= 1'b0;
      end else if (r_rwait_busy && w_tick) begin
         r_rwait_cnt <= r_rwait_cnt - RW_ONE;
         if (r_rwait_cnt <= RW_ONE) begin
            r_rwait_busy <= 1'b0;
            r_rwait_done <= 1'b1;
         end
      end
   end

   // Hold timer runs only while start_wait5 is high; done trails the terminal count by a cycle.
   always_ff @(posedge clk) begin
      if (!rst || !bus.start_wait5) begin
         r_hold_cnt   <= '0;
         r_wait5_done <= 1'b0;
      end else begin
         if (w_tick) r_hold_cnt <= sat_inc_hold(r_hold_cnt);
         r_wait5_done <= (r_hold_cnt == HOLD_MAX);
      end
   end

   // Reaction counter with clear priority; late flag set on the edge that reaches the threshold.
   always_ff @(posedge clk) begin
      if (!rst || bus.time_clr) begin
         r_time      <= '0;
         r_time_late <= 1'b0;
      end else if (w_time_inc) begin
         r_time <= sat_inc_time(r_time);
         if (r_time == LATE_PRE) r_time_late <= 1'b1;
      end
   end

   // Result store on the rs_en rising edge; best keeps the minimum seen.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rs_q       <= 1'b0;
         r_last       <= '0;
         r_best       <= '1;
         r_best_valid <= 1'b0;
      end else begin
         r_rs_q <= bus.rs_en;
         if (w_rs_rise) begin
            r_last       <= r_time;
            r_best_valid <= 1'b1;
            if (r_time < r_best) r_best <= r_time;
         end
      end
   end

   assign bus.rwait_done = r_rwait_done;
   assign bus.wait5_done = r_wait5_done;
   assign bus.time_late  = r_time_late;
   assign bus.time_ms    = r_time;
   assign bus.last_ms    = r_last;
   assign bus.best_ms    = r_best;
   assign bus.best_valid = r_best_valid;

endmodule

// File: tb/tb_reaction_timer_dp.sv
// Directed bench for reaction_timer_dp: two instances share clk/rst, one with a
// large late threshold for measurement, one with LATE_MS=20 for saturation.
module tb_reaction_timer_dp;

   localparam int TW = 14;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   logic [15:0] m_lfsr;

   reaction_timer_dp_if #(.TW(TW)) a_if ();
   reaction_timer_dp_if #(.TW(TW)) b_if ();

   reaction_timer_dp #(
      .MS_DIV(4), .RWAIT_MIN_MS(10), .RAND_BITS(2), .WAIT5_MS(50),
      .LATE_MS(9999), .TW(TW), .LFSR_SEED(16'hACE1)
   ) u_dut_a (
      .clk(clk), .rst(rst), .bus(a_if)
   );

   reaction_timer_dp #(
      .MS_DIV(4), .RWAIT_MIN_MS(10), .RAND_BITS(2), .WAIT5_MS(50),
      .LATE_MS(20), .TW(TW), .LFSR_SEED(16'hACE1)
   ) u_dut_b (
      .clk(clk), .rst(rst), .bus(b_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference LFSR: 16-bit Galois, mask B400, right shift every clock.
   always @(posedge clk) begin
      if (!rst) m_lfsr <= 16'hACE1;
      else      m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One measurement: align with time_clr, run n ticks, then raise rs_en.
   task automatic measure(input int n, input int exp_best);
      a_if.rs_en    = 1'b0;
      a_if.time_clr = 1'b1;
      cyc(1);
      a_if.time_clr = 1'b0;
      a_if.time_en  = 1'b1;
      cyc(4 * n);
      a_if.time_en  = 1'b0;
      chk("meas_time", 32'(a_if.time_ms), 32'(n));
      a_if.rs_en = 1'b1;
      cyc(1);
      chk("meas_last",  32'(a_if.last_ms), 32'(n));
      chk("meas_best",  32'(a_if.best_ms), 32'(exp_best));
      chk("meas_valid", 32'(a_if.best_valid), 32'd1);
   endtask

   initial begin
      int k;
      int cnt;
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b0;
      a_if.start_rwait = 1'b0; a_if.start_wait5 = 1'b0; a_if.time_clr = 1'b0;
      a_if.time_en = 1'b0; a_if.rs_en = 1'b0;
      b_if.start_rwait = 1'b0; b_if.start_wait5 = 1'b0; b_if.time_clr = 1'b0;
      b_if.time_en = 1'b0; b_if.rs_en = 1'b0;

      // Reset defaults
      cyc(3);
      chk("rst_rwait_done", 32'(a_if.rwait_done), 32'd0);
      chk("rst_wait5_done", 32'(a_if.wait5_done), 32'd0);
      chk("rst_time_late",  32'(a_if.time_late), 32'd0);
      chk("rst_time_ms",    32'(a_if.time_ms), 32'd0);
      chk("rst_last_ms",    32'(a_if.last_ms), 32'd0);
      chk("rst_best_ms",    32'(a_if.best_ms), 32'd16383);
      chk("rst_best_valid", 32'(a_if.best_valid), 32'd0);
      rst = 1'b1;
      cyc(7);

      // Random wait, prescaler aligned by time_clr on the load edge
      k = int'(m_lfsr[1:0]);
      a_if.start_rwait = 1'b1;
      a_if.time_clr    = 1'b1;
      cyc(1);
      a_if.start_rwait = 1'b0;
      a_if.time_clr    = 1'b0;
      chk("rwait_clear_on_load", 32'(a_if.rwait_done), 32'd0);
      cnt = 0;
      while (cnt < 200 && a_if.rwait_done !== 1'b1) begin
         cyc(1);
         cnt++;
      end
      chk("rwait_latency_cycles", 32'(cnt), 32'(4 * (10 + k)));
      cyc(20);
      chk("rwait_done_holds", 32'(a_if.rwait_done), 32'd1);
      a_if.start_rwait = 1'b1;
      cyc(1);
      a_if.start_rwait = 1'b0;
      chk("rwait_restart_clears", 32'(a_if.rwait_done), 32'd0);

      // Measurement and best tracking
      measure(250, 250);
      a_if.time_clr = 1'b1;
      cyc(2);
      a_if.time_clr = 1'b0;
      chk("rs_held_no_capture", 32'(a_if.last_ms), 32'd250);
      measure(300, 250);
      measure(120, 120);
      a_if.rs_en = 1'b0;

      // Late saturation on the LATE_MS=20 instance
      b_if.time_clr = 1'b1;
      cyc(1);
      b_if.time_clr = 1'b0;
      b_if.time_en  = 1'b1;
      cyc(4 * 19);
      chk("late_t19_time", 32'(b_if.time_ms), 32'd19);
      chk("late_t19_flag", 32'(b_if.time_late), 32'd0);
      cyc(4);
      chk("late_t20_time", 32'(b_if.time_ms), 32'd20);
      chk("late_t20_flag", 32'(b_if.time_late), 32'd1);
      cyc(40);
      chk("late_sat_time", 32'(b_if.time_ms), 32'd20);
      chk("late_sat_flag", 32'(b_if.time_late), 32'd1);
      b_if.time_en  = 1'b0;
      b_if.time_clr = 1'b1;
      cyc(1);
      chk("late_clr_time", 32'(b_if.time_ms), 32'd0);
      chk("late_clr_flag", 32'(b_if.time_late), 32'd0);
      b_if.time_en = 1'b1;
      cyc(12);
      chk("clr_beats_en", 32'(b_if.time_ms), 32'd0);
      b_if.time_clr = 1'b0;
      cyc(8);
      chk("count_after_clr", 32'(b_if.time_ms), 32'd2);
      b_if.time_en = 1'b0;
      cyc(12);
      chk("freeze_en_low", 32'(b_if.time_ms), 32'd2);

      // Hold timer, full run
      a_if.time_clr = 1'b1;
      cyc(1);
      a_if.time_clr    = 1'b0;
      a_if.start_wait5 = 1'b1;
      cyc(200);
      chk("hold_tick50_not_yet", 32'(a_if.wait5_done), 32'd0);
      cyc(1);
      chk("hold_done", 32'(a_if.wait5_done), 32'd1);
      cyc(20);
      chk("hold_done_stays", 32'(a_if.wait5_done), 32'd1);
      a_if.start_wait5 = 1'b0;
      cyc(1);
      chk("hold_drop_clears", 32'(a_if.wait5_done), 32'd0);

      // Hold timer, dropped at tick 30 then restarted
      a_if.time_clr = 1'b1;
      cyc(1);
      a_if.time_clr    = 1'b0;
      a_if.start_wait5 = 1'b1;
      cyc(120);
      a_if.start_wait5 = 1'b0;
      cyc(1);
      chk("hold_mid_drop", 32'(a_if.wait5_done), 32'd0);
      a_if.start_wait5 = 1'b1;
      cyc(196);
      chk("hold_restart_49", 32'(a_if.wait5_done), 32'd0);
      cyc(8);
      chk("hold_restart_done", 32'(a_if.wait5_done), 32'd1);
      a_if.start_wait5 = 1'b0;

      // Reset in the middle of a random-wait countdown
      a_if.start_rwait = 1'b1;
      cyc(1);
      a_if.start_rwait = 1'b0;
      cyc(10);
      rst = 1'b0;
      cyc(2);
      rst = 1'b1;
      cyc(100);
      chk("midrst_rwait_done", 32'(a_if.rwait_done), 32'd0);
      chk("midrst_best_ms",    32'(a_if.best_ms), 32'd16383);
      chk("midrst_best_valid", 32'(a_if.best_valid), 32'd0);
      chk("midrst_last_ms",    32'(a_if.last_ms), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
